disp_arbiter: RTL and testbench

- Shares the 8-digit temperature/humidity display driver among up to N_REQ requesters: live sensor path, setpoint editor, alarm page.
- Grants the display to one requester at a time for a minimum dwell period.
- Re-arbitrates round-robin between contenders when the dwell expires.
- Inserts a short blank gap on every hand-over, and drives the driver's 32-bit Disp_Data word.

---
 rtl/disp_pkg.sv | 27 ++
 rtl/rr_pick.sv | 38 +++
 rtl/disp_arbiter.sv | 142 ++++++++++++++
 tb/tb_disp_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
`default_nettype none
// disp_pkg: shared constants, FSM state encoding and the 3-digit display clamp.
// Rev 1.0
package disp_pkg;

    localparam int DWELL_CYC_DEF = 200_000_000;
    localparam int GAP_CYC_DEF   = 20_000_000;

    localparam logic [15:0] DISP_MAX = 16'd999;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } disp_state_e;

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v > DISP_MAX) ? DISP_MAX : v;
    endfunction

    // Humidity (upper half) and temperature (lower half) clamp independently.
    function automatic logic [31:0] sat32(input logic [31:0] w);
        return {sat16(w[31:16]), sat16(w[15:0])};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// rr_pick: wrapping priority search over req_i starting at ptr_i; first set bit wins.
// Rev 1.0
module rr_pick #(
    parameter int N_REQ = 3,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    localparam logic [IDX_W:0] C_N = (IDX_W+1)'(N_REQ);

    logic [N_REQ-1:0] w_rot;
    logic [IDX_W-1:0] w_off;
    logic [IDX_W:0]   w_sum;

    // Rotating a doubled copy puts the search start at bit 0.
    assign w_rot = N_REQ'({req_i, req_i} >> ptr_i);

    always_comb begin
        found_o = 1'b0;
        w_off   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                found_o = 1'b1;
                w_off   = IDX_W'(i);
            end
        end
    end

    assign w_sum = {1'b0, ptr_i} + {1'b0, w_off};
    assign idx_o = (w_sum >= C_N) ? IDX_W'(w_sum - C_N) : w_sum[IDX_W-1:0];

endmodule
`default_nettype wire

// File: rtl/disp_arbiter.sv
`default_nettype none
// disp_arbiter: round-robin display ownership with minimum dwell and blank gap on hand-over.
// Rev 1.0
module disp_arbiter
    import disp_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int DWELL_CYC = DWELL_CYC_DEF,
    parameter int GAP_CYC   = GAP_CYC_DEF,
    parameter int CNT_W     = 28
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [N_REQ-1:0]     Req,
    input  logic [32*N_REQ-1:0]  Req_Data,
    output logic [N_REQ-1:0]     Grant,
    output logic [31:0]          Disp_Data,
    output logic                 Disp_Valid,
    output logic                 Blank
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W-1:0] C_LAST       = IDX_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] C_DWELL_LAST = CNT_W'(DWELL_CYC - 1);
    localparam logic [CNT_W-1:0] C_GAP_LAST   = CNT_W'(GAP_CYC - 1);

    disp_state_e      state_q;
    logic [IDX_W-1:0] owner_q;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [N_REQ-1:0] grant_q;
    logic [31:0]      data_q;
    logic             valid_q;
    logic             blank_q;

    logic [31:0]      w_slice [N_REQ];
    logic             w_pick_found;
    logic [IDX_W-1:0] w_pick_idx;
    logic [IDX_W-1:0] w_next_ptr;
    logic [N_REQ-1:0] w_pick_onehot;
    logic [31:0]      w_pick_data;
    logic [31:0]      w_hold_data;
    logic             w_owner_req;
    logic             w_others;
    logic             w_dwell_end;
    logic             w_gap_end;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
        assign w_slice[gi] = Req_Data[32*gi +: 32];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i   (Req),
        .ptr_i   (rr_ptr_q),
        .found_o (w_pick_found),
        .idx_o   (w_pick_idx)
    );

    assign w_next_ptr    = (w_pick_idx == C_LAST) ? '0 : w_pick_idx + 1'b1;
    assign w_pick_onehot = N_REQ'(1) << w_pick_idx;
    assign w_pick_data   = sat32(w_slice[w_pick_idx]);
    assign w_hold_data   = sat32(w_slice[owner_q]);
    assign w_owner_req   = Req[owner_q];
    // grant_q is the owner's one-hot while holding, so this masks out the owner.
    assign w_others      = |(Req & ~grant_q);
    assign w_dwell_end   = (cnt_q == C_DWELL_LAST);
    assign w_gap_end     = (cnt_q == C_GAP_LAST);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            grant_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            blank_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_pick_found) begin
                        state_q  <= ST_HOLD;
                        owner_q  <= w_pick_idx;
                        rr_ptr_q <= w_next_ptr;
                        cnt_q    <= '0;
                        grant_q  <= w_pick_onehot;
                        data_q   <= w_pick_data;
                        valid_q  <= 1'b1;
                        blank_q  <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    data_q <= w_hold_data;
                    // Owner release wins over dwell expiry; contention only counts at expiry.
                    if (!w_owner_req || (w_dwell_end && w_others)) begin
                        state_q <= ST_GAP;
                        cnt_q   <= '0;
                        grant_q <= '0;
                        valid_q <= 1'b0;
                        blank_q <= 1'b1;
                    end else if (w_dwell_end) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (w_gap_end) begin
                        if (w_pick_found) begin
                            state_q  <= ST_HOLD;
                            owner_q  <= w_pick_idx;
                            rr_ptr_q <= w_next_ptr;
                            cnt_q    <= '0;
                            grant_q  <= w_pick_onehot;
                            data_q   <= w_pick_data;
                            valid_q  <= 1'b1;
                            blank_q  <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                            blank_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign Grant      = grant_q;
    assign Disp_Data  = data_q;
    assign Disp_Valid = valid_q;
    assign Blank      = blank_q;

endmodule
`default_nettype wire

// File: tb/tb_disp_arbiter.sv
`default_nettype none
// tb_disp_arbiter: directed scenarios plus randomized traffic against a behavioural ownership model.
// Rev 1.0
module tb_disp_arbiter;

    localparam int N  = 3;
    localparam int DW = 10;
    localparam int GP = 2;

    logic            Clk = 1'b0;
    logic            Reset = 1'b1;
    logic [N-1:0]    Req = '0;
    logic [32*N-1:0] Req_Data = '0;
    logic [N-1:0]    Grant;
    logic [31:0]     Disp_Data;
    logic            Disp_Valid;
    logic            Blank;

    int n_tests = 0;
    int n_fail  = 0;

    disp_arbiter #(
        .N_REQ     (N),
        .DWELL_CYC (DW),
        .GAP_CYC   (GP),
        .CNT_W     (8)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Req        (Req),
        .Req_Data   (Req_Data),
        .Grant      (Grant),
        .Disp_Data  (Disp_Data),
        .Disp_Valid (Disp_Valid),
        .Blank      (Blank)
    );

    always #5 Clk = ~Clk;

    // Model: who owns the display, how long the current phase has lasted, who is next in line.
    int          m_phase;   // 0 = nobody, 1 = owned, 2 = blank gap
    int          m_owner;
    int          m_next;
    int          m_age;
    logic [31:0] m_word;
    bit          m_fresh;

    function automatic int clamp999(int v);
        return (v > 999) ? 999 : v;
    endfunction

    function automatic logic [31:0] shown(int k);
        logic [31:0] w;
        w = Req_Data[32*k +: 32];
        return {16'(clamp999(int'(w[31:16]))), 16'(clamp999(int'(w[15:0])))};
    endfunction

    function automatic void m_award();
        for (int i = 0; i < N; i++) begin
            if (Req[(m_next + i) % N]) begin
                m_owner = (m_next + i) % N;
                m_next  = (m_owner + 1) % N;
                m_phase = 1;
                m_age   = 0;
                m_word  = shown(m_owner);
                m_fresh = 1'b0;
                return;
            end
        end
    endfunction

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_phase = 0; m_owner = 0; m_next = 0; m_age = 0; m_word = '0; m_fresh = 1'b1;
        end else begin
            case (m_phase)
                0: if (Req != 0) m_award();
                1: begin
                    m_word = shown(m_owner);
                    if (!Req[m_owner]) begin
                        m_phase = 2; m_age = 0;
                    end else if (m_age == DW - 1) begin
                        m_age = 0;
                        if ((Req & ~(N'(1) << m_owner)) != 0) m_phase = 2;
                    end else begin
                        m_age++;
                    end
                end
                default: begin
                    if (m_age == GP - 1) begin
                        if (Req != 0) m_award();
                        else m_phase = 0;
                    end else begin
                        m_age++;
                    end
                end
            endcase
        end
    end

    function automatic logic [36:0] exp_vec();
        logic [N-1:0] g;
        logic         b;
        g = (m_phase == 1) ? N'(1) << m_owner : '0;
        b = (m_phase == 2) || (m_phase == 0 && m_fresh);
        return {g, m_word, (m_phase == 1), b};
    endfunction

    task automatic go_idle();
        Req = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clk);
            n_tests++;
            if ({Grant, Disp_Data, Disp_Valid, Blank} !== exp_vec()) begin
                n_fail++;
                $display("FAIL go_idle c%0d: got %h want %h", c, {Grant, Disp_Data, Disp_Valid, Blank}, exp_vec());
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; Req = '0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        n_tests++;
        if ({Grant, Disp_Data, Disp_Valid, Blank} !== {3'b000, 32'h0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_idle: got %h want %h", {Grant, Disp_Data, Disp_Valid, Blank}, {3'b000, 32'h0, 1'b0, 1'b1});
        end
        Req_Data[31:0] = 32'h0012_0034;
        Req = 3'b001;
        repeat (3) @(negedge Clk);
        n_tests++;
        if (Grant !== 3'b001 || Disp_Valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_hold: got grant %b valid %b want 001 1", Grant, Disp_Valid);
        end
        #2 Reset = 1'b1;
        #1;
        n_tests++;
        if ({Grant, Disp_Data, Disp_Valid, Blank} !== {3'b000, 32'h0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL async_reset: got %h want %h", {Grant, Disp_Data, Disp_Valid, Blank}, {3'b000, 32'h0, 1'b0, 1'b1});
        end
        @(negedge Clk);
        Reset = 1'b0; Req = '0;
        @(negedge Clk);
        n_tests++;
        if ({Grant, Disp_Data, Disp_Valid, Blank} !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_release: got %h want %h", {Grant, Disp_Data, Disp_Valid, Blank}, exp_vec());
        end
    endtask

    task automatic test_grant_follow();
        Req_Data[31:0] = 32'h0041_0019;
        Req = 3'b001;
        @(negedge Clk);
        n_tests++;
        if (Grant !== 3'b001 || Disp_Valid !== 1'b1 || Disp_Data !== 32'h0041_0019) begin
            n_fail++;
            $display("FAIL first_grant: got %b %b %h want 001 1 00410019", Grant, Disp_Valid, Disp_Data);
        end
        Req_Data[31:0] = 32'h0042_0019;
        @(negedge Clk);
        n_tests++;
        if (Disp_Data !== 32'h0042_0019 || {Grant, Disp_Data, Disp_Valid, Blank} !== exp_vec()) begin
            n_fail++;
            $display("FAIL live_follow: got %h want %h", {Grant, Disp_Data, Disp_Valid, Blank}, exp_vec());
        end
        go_idle();
    endtask

    task automatic test_round_robin();
        int brun = 0;
        int grun = 0;
        Req = 3'b011;
        for (int c = 0; c < 60; c++) begin
            @(negedge Clk);
            n_tests++;
            if ({Grant, Disp_Data, Disp_Valid, Blank} !== exp_vec() || !$onehot0(Grant)) begin
                n_fail++;
                $display("FAIL rr_model c%0d: got %h want %h", c, {Grant, Disp_Data, Disp_Valid, Blank}, exp_vec());
            end
            if (Blank) brun++;
            else begin
                if (brun != 0) begin
                    n_tests++;
                    if (brun != GP) begin
                        n_fail++;
                        $display("FAIL rr_gap_len c%0d: got %0d want %0d", c, brun, GP);
                    end
                end
                brun = 0;
            end
            if (Grant != 0) grun++;
            else begin
                if (grun != 0) begin
                    n_tests++;
                    if (grun != DW) begin
                        n_fail++;
                        $display("FAIL rr_dwell_len c%0d: got %0d want %0d", c, grun, DW);
                    end
                end
                grun = 0;
            end
        end
        go_idle();
    endtask

    task automatic test_early_release();
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        Req = 3'b101;
        @(negedge Clk);
        n_tests++;
        if (Grant !== 3'b001) begin
            n_fail++;
            $display("FAIL early_owner: got %b want 001", Grant);
        end
        repeat (3) @(negedge Clk);
        Req = 3'b100;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            n_tests++;
            if ({Grant, Blank} !== ((c < 2) ? 4'b0001 : 4'b1000) || {Grant, Disp_Data, Disp_Valid, Blank} !== exp_vec()) begin
                n_fail++;
                $display("FAIL early_gap c%0d: got %h want %h", c, {Grant, Disp_Data, Disp_Valid, Blank}, exp_vec());
            end
        end
        go_idle();
    endtask

    task automatic test_saturation();
        logic [31:0] vin  [3];
        logic [31:0] vexp [3];
        vin[0] = 32'h04D2_0000; vexp[0] = 32'h03E7_0000;
        vin[1] = 32'hFFFF_03E8; vexp[1] = 32'h03E7_03E7;
        vin[2] = 32'h03E6_03E7; vexp[2] = 32'h03E6_03E7;
        Req_Data[63:32] = vin[0];
        Req = 3'b010;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            n_tests++;
            if (Disp_Data !== vexp[i]) begin
                n_fail++;
                $display("FAIL sat_%0d: got %h want %h", i, Disp_Data, vexp[i]);
            end
            if (i < 2) Req_Data[63:32] = vin[i+1];
        end
        go_idle();
    endtask

    task automatic test_single_owner();
        Req_Data[63:32] = 32'h0011_0022;
        Req = 3'b010;
        for (int c = 0; c < 25; c++) begin
            @(negedge Clk);
            n_tests++;
            if (Grant !== 3'b010 || Blank !== 1'b0) begin
                n_fail++;
                $display("FAIL solo_hold c%0d: got grant %b blank %b want 010 0", c, Grant, Blank);
            end
        end
        Req = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            n_tests++;
            if ((c < 2 && {Grant, Blank} !== 4'b0001) ||
                (c == 2 && {Grant, Disp_Data, Disp_Valid, Blank} !== {3'b000, 32'h0011_0022, 1'b0, 1'b0})) begin
                n_fail++;
                $display("FAIL solo_release c%0d: got %h", c, {Grant, Disp_Data, Disp_Valid, Blank});
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            @(negedge Clk);
            n_tests++;
            if ({Grant, Disp_Data, Disp_Valid, Blank} !== exp_vec() || !$onehot0(Grant)) begin
                n_fail++;
                $display("FAIL random c%0d: got %h want %h", c, {Grant, Disp_Data, Disp_Valid, Blank}, exp_vec());
            end
            if (Reset) Reset = 1'b0;
            else if ($urandom_range(249) == 0) Reset = 1'b1;
            if ($urandom_range(5) == 0) Req = N'($urandom_range(7));
            for (int i = 0; i < N; i++)
                if ($urandom_range(2) == 0)
                    Req_Data[32*i +: 32] = {16'($urandom_range(1100)), 16'($urandom_range(1100))};
        end
        Reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_grant_follow();
        test_round_robin();
        test_early_release();
        test_saturation();
        test_single_owner();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
